// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and state type for the sliced subtractor
package arith_pkg;
  localparam int WIDTH  = 128;
  localparam int SLICE  = 7;
  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int PWIDTH = NSLICE * SLICE;
  localparam int IDX_W  = $clog2(NSLICE);

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational SLICE-bit subtract with borrow in/out
module sub_slice
  import arith_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  logic [SLICE:0] res;

  // One extra bit wide: the top bit goes high exactly when a < b + bin.
  always_comb begin
    res  = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    d    = res[SLICE-1:0];
    bout = res[SLICE];
  end
endmodule

// File: rtl/sub_128bit_seq.sv
// rtl/sub_128bit_seq.sv - multi-cycle unsigned subtractor, one slice per clock
module sub_128bit_seq
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                borrow_q, borrow_d;
  logic [PWIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]    diff_q, diff_d;
  logic                borrow_out_q, borrow_out_d;
  logic                done_q, done_d;

  logic [SLICE-1:0]    s_a, s_b, s_d;
  logic                s_bout;

  always_comb begin
    s_a = a_q[int'(idx_q)*SLICE +: SLICE];
    s_b = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  sub_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (borrow_q),
    .d    (s_d),
    .bout (s_bout)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = {{(PWIDTH-WIDTH){1'b0}}, a};
          b_d      = {{(PWIDTH-WIDTH){1'b0}}, b};
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        borrow_d = s_bout;
        idx_d    = idx_q + IDX_W'(1);
        // Only real result bits are written; the padded top of the last slice is dropped.
        for (int i = 0; i < WIDTH; i++) begin
          if (i / SLICE == int'(idx_q)) diff_d[i] = s_d[i % SLICE];
        end
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          borrow_out_d = s_bout;
          done_d       = 1'b1;
          idx_d        = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
endmodule

// File: tb/tb_sub_128bit_seq.sv
// tb/tb_sub_128bit_seq.sv - randomized self-checking bench for sub_128bit_seq
module tb_sub_128bit_seq;
  localparam int W   = 128;
  localparam int LAT = 19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  sub_128bit_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return x - y;
  endfunction

  function automatic logic [W-1:0] ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y) ? W'(1) : W'(0);
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns #1 after the done edge.
  task automatic wait_done(output int lat, output int bc);
    bc  = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input int lat, input int bc);
    check({tag, "_lat"}, W'(lat), W'(LAT));
    check({tag, "_busy"}, W'(bc), W'(LAT));
    check({tag, "_diff"}, diff, ref_diff(x, y));
    check({tag, "_borrow"}, W'(borrow_out), ref_borrow(x, y));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat, bc;
    start_op(x, y);
    wait_done(lat, bc);
    check_result(tag, x, y, lat, bc);
  endtask

  initial begin
    int lat, bc, dcount;
    logic [W-1:0] held, x, y;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_diff", diff, W'(0));
    check("rst_borrow", W'(borrow_out), W'(0));
    rst_n = 1'b1;

    run_op("5m3", W'(5), W'(3));
    held = diff;
    @(posedge clk);
    #1;
    check("done_pulse", W'(done), W'(0));
    check("diff_held", diff, held);

    run_op("0m1", W'(0), W'(1));
    run_op("msb_m1", {1'b1, {(W-1){1'b0}}}, W'(1));
    x = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    run_op("equal", x, x);

    // start while busy must be ignored
    start_op(W'(10), W'(4));
    bc  = 1;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (busy) bc++;
      if (lat == 5) begin
        a_i   = W'(1);
        b_i   = W'(2);
        start = 1'b1;
      end
    end
    start = 1'b0;
    check_result("ignore", W'(10), W'(4), lat, bc);

    // reset mid-operation
    start_op(W'(100), W'(7));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_diff", diff, W'(0));
    check("abort_borrow", W'(borrow_out), W'(0));
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done", W'(dcount), W'(0));
    run_op("9m9", W'(9), W'(9));

    // back-to-back: start issued in the done cycle
    start_op(W'(20), W'(8));
    wait_done(lat, bc);
    check_result("b2b_first", W'(20), W'(8), lat, bc);
    a_i   = W'(3);
    b_i   = W'(5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_no_gap", W'(busy), W'(1));
    wait_done(lat, bc);
    check_result("b2b_second", W'(3), W'(5), lat, bc);

    for (int r = 0; r < 12; r++) begin
      x = rand128();
      y = rand128();
      if (r % 3 == 1) y = {x[W-1:32], y[31:0]};
      if (r % 4 == 2) y = x ^ (W'(1) << $urandom_range(0, W-1));
      run_op($sformatf("rand%0d", r), x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
